// File: rtl/pcileech_eth_rmii_tx.sv
// rtl/pcileech_eth_rmii_tx.sv - RMII transmit framer: preamble/SFD, LSB-first dibits, pad to 60, IFG.
// Define PCILEECH_ETH_TX_FCS_EN to append a generated CRC-32 FCS; otherwise the source supplies it.
module pcileech_eth_rmii_tx #(
  parameter int IFG_BYTES = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_tdata,
  input  logic       s_tvalid,
  input  logic       s_tlast,
  output logic       s_tready,
  output logic       eth_tx_en,
  output logic [1:0] eth_tx_data,
  output logic       busy,
  output logic       underrun
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PREAMBLE = 3'd1;
  localparam logic [2:0] S_SFD      = 3'd2;
  localparam logic [2:0] S_DATA     = 3'd3;
  localparam logic [2:0] S_PAD      = 3'd4;
`ifdef PCILEECH_ETH_TX_FCS_EN
  localparam logic [2:0] S_FCS      = 3'd5;
`endif
  localparam logic [2:0] S_IFG      = 3'd6;
  localparam logic [2:0] S_DISCARD  = 3'd7;

  // IFG state is one cycle short; the IDLE cycle before the next preamble completes the gap.
  localparam logic [9:0]  IFG_LAST  = 10'(4 * IFG_BYTES - 2);
  localparam logic [10:0] MIN_BYTES = 11'd60;

  logic [2:0]  state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [1:0]  dib_q, dib_d;
  logic [7:0]  sh_q, sh_d;
  logic        last_q, last_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic        tx_en_q, tx_en_d;
  logic [1:0]  txd_q, txd_d;
  logic        underrun_q, underrun_d;

  logic        load_en;
  logic [7:0]  load_val;
  logic        load_last;

`ifdef PCILEECH_ETH_TX_FCS_EN
  logic [31:0] crc_q, crc_d;
  logic [31:0] fcs_q, fcs_d;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction
`endif

  always_comb begin
    s_tready = 1'b0;
    case (state_q)
      S_SFD:     s_tready = (cnt_q == 10'd3);
      S_DATA:    s_tready = (dib_q == 2'd3) && !last_q;
      S_DISCARD: s_tready = 1'b1;
      default:   s_tready = 1'b0;
    endcase
  end

  // Outputs are registered from the next-cycle decision so the wire shows the current state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dib_d      = dib_q + 2'd1;
    sh_d       = {2'b00, sh_q[7:2]};
    last_d     = last_q;
    byte_cnt_d = byte_cnt_q;
    tx_en_d    = 1'b0;
    txd_d      = 2'b00;
    underrun_d = 1'b0;
    load_en    = 1'b0;
    load_val   = s_tdata;
    load_last  = s_tlast;
`ifdef PCILEECH_ETH_TX_FCS_EN
    crc_d      = crc_q;
    fcs_d      = {2'b00, fcs_q[31:2]};
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d      = 10'd0;
        byte_cnt_d = 11'd0;
        if (s_tvalid) begin
          state_d = S_PREAMBLE;
          tx_en_d = 1'b1;
          txd_d   = 2'b01;
`ifdef PCILEECH_ETH_TX_FCS_EN
          crc_d   = 32'hFFFFFFFF;
`endif
        end
      end
      S_PREAMBLE: begin
        tx_en_d = 1'b1;
        txd_d   = 2'b01;
        if (cnt_q == 10'd27) begin
          state_d = S_SFD;
          cnt_d   = 10'd0;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      S_SFD: begin
        if (cnt_q != 10'd3) begin
          tx_en_d = 1'b1;
          txd_d   = (cnt_q == 10'd2) ? 2'b11 : 2'b01;
          cnt_d   = cnt_q + 10'd1;
        end else if (s_tvalid) begin
          state_d = S_DATA;
          load_en = 1'b1;
        end else begin
          state_d    = S_DISCARD;
          underrun_d = 1'b1;
        end
      end
      S_DATA, S_PAD: begin
        if (dib_q != 2'd3) begin
          tx_en_d = 1'b1;
          txd_d   = sh_q[1:0];
        end else if (!last_q) begin
          if (s_tvalid) begin
            load_en = 1'b1;
          end else begin
            state_d    = S_DISCARD;
            underrun_d = 1'b1;
          end
        end else if (byte_cnt_q < MIN_BYTES) begin
          state_d   = S_PAD;
          load_en   = 1'b1;
          load_val  = 8'h00;
          load_last = 1'b1;
        end else begin
`ifdef PCILEECH_ETH_TX_FCS_EN
          state_d = S_FCS;
          cnt_d   = 10'd0;
          tx_en_d = 1'b1;
          txd_d   = ~crc_q[1:0];
          fcs_d   = {2'b00, ~crc_q[31:2]};
`else
          state_d = S_IFG;
          cnt_d   = 10'd0;
`endif
        end
      end
`ifdef PCILEECH_ETH_TX_FCS_EN
      S_FCS: begin
        if (cnt_q == 10'd15) begin
          state_d = S_IFG;
          cnt_d   = 10'd0;
        end else begin
          tx_en_d = 1'b1;
          txd_d   = fcs_q[1:0];
          cnt_d   = cnt_q + 10'd1;
        end
      end
`endif
      S_IFG: begin
        if (cnt_q == IFG_LAST) begin
          state_d = S_IDLE;
          cnt_d   = 10'd0;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      S_DISCARD: begin
        if (s_tvalid && s_tlast) begin
          state_d = S_IFG;
          cnt_d   = 10'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load_en) begin
      tx_en_d = 1'b1;
      txd_d   = load_val[1:0];
      sh_d    = {2'b00, load_val[7:2]};
      dib_d   = 2'd0;
      last_d  = load_last;
      if (byte_cnt_q != 11'h7FF) begin
        byte_cnt_d = byte_cnt_q + 11'd1;
      end
`ifdef PCILEECH_ETH_TX_FCS_EN
      crc_d = crc32_byte(crc_q, load_val);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 10'd0;
      dib_q      <= 2'd0;
      sh_q       <= 8'h00;
      last_q     <= 1'b0;
      byte_cnt_q <= 11'd0;
      tx_en_q    <= 1'b0;
      txd_q      <= 2'b00;
      underrun_q <= 1'b0;
`ifdef PCILEECH_ETH_TX_FCS_EN
      crc_q      <= 32'hFFFFFFFF;
      fcs_q      <= 32'h00000000;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dib_q      <= dib_d;
      sh_q       <= sh_d;
      last_q     <= last_d;
      byte_cnt_q <= byte_cnt_d;
      tx_en_q    <= tx_en_d;
      txd_q      <= txd_d;
      underrun_q <= underrun_d;
`ifdef PCILEECH_ETH_TX_FCS_EN
      crc_q      <= crc_d;
      fcs_q      <= fcs_d;
`endif
    end
  end

  assign eth_tx_en   = tx_en_q;
  assign eth_tx_data = txd_q;
  assign underrun    = underrun_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_pcileech_eth_rmii_tx.sv
// tb/tb_pcileech_eth_rmii_tx.sv - directed vector bench for the RMII transmit framer
module tb_pcileech_eth_rmii_tx;

  localparam int IFG_BYTES = 12;
  localparam int IFG_CYC   = 4 * IFG_BYTES;
`ifdef PCILEECH_ETH_TX_FCS_EN
  localparam int FCS_CYC = 16;
`else
  localparam int FCS_CYC = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_tdata = 8'h00;
  logic       s_tvalid = 1'b0;
  logic       s_tlast = 1'b0;
  logic       s_tready;
  logic       eth_tx_en;
  logic [1:0] eth_tx_data;
  logic       busy;
  logic       underrun;

  always #10 clk = ~clk;

  pcileech_eth_rmii_tx #(.IFG_BYTES(IFG_BYTES)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tlast    (s_tlast),
    .s_tready   (s_tready),
    .eth_tx_en  (eth_tx_en),
    .eth_tx_data(eth_tx_data),
    .busy       (busy),
    .underrun   (underrun)
  );

  typedef struct {
    string name;
    int    kind;      // 0: incrementing bytes, 1: "123456789" then incrementing, 2: 0xA5
    int    len;
    int    stall;     // byte index where s_tvalid drops once, -1 for none
    int    exp_hi;
    int    exp_rises;
    int    exp_acc;
    int    exp_ur;
    int    exp_gap;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0] src[$];
  int         src_idx = 0;
  int         stall_at = -1;
  bit         stalled = 1'b0;

  logic       log_en[$];
  logic [1:0] log_d[$];
  logic       log_rdy[$];
  logic       log_busy[$];
  logic       log_ur[$];
  logic       log_acc[$];

  logic [7:0] wire_bytes[$];
  logic [1:0] exp_d[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_inputs();
    logic [8:0] e;
    if (src_idx < src.size()) begin
      e        = src[src_idx];
      s_tdata  = e[7:0];
      s_tlast  = e[8];
      s_tvalid = 1'b1;
      if (src_idx == stall_at && s_tready && !stalled) begin
        s_tvalid = 1'b0;
        stalled  = 1'b1;
      end
    end else begin
      s_tdata  = 8'h00;
      s_tlast  = 1'b0;
      s_tvalid = 1'b0;
    end
  endtask

  task automatic step();
    logic acc;
    @(negedge clk);
    acc = s_tvalid && s_tready;
    log_en.push_back(eth_tx_en);
    log_d.push_back(eth_tx_data);
    log_rdy.push_back(s_tready);
    log_busy.push_back(busy);
    log_ur.push_back(underrun);
    log_acc.push_back(acc);
    @(posedge clk);
    #1;
    if (acc) src_idx++;
    drive_inputs();
  endtask

  task automatic start_run();
    log_en.delete(); log_d.delete(); log_rdy.delete();
    log_busy.delete(); log_ur.delete(); log_acc.delete();
    src_idx = 0;
    stalled = 1'b0;
    drive_inputs();
  endtask

  task automatic run_to_idle(input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 4000 && !done; c++) begin
      step();
      if (src_idx >= src.size() && log_busy[log_busy.size()-1] == 1'b0) done = 1'b1;
    end
    check({name, " completes"}, done, 1);
  endtask

  task automatic load_frame(input int kind, input int len);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      case (kind)
        1:       b = (i < 9) ? (8'h31 + 8'(i)) : 8'(i);
        2:       b = 8'hA5;
        default: b = 8'(i);
      endcase
      src.push_back({(i == len - 1), b});
    end
  endtask

  function automatic logic [31:0] fcs_of(input int n);
    logic [31:0] c;
    logic [7:0]  b;
    logic        fb;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      b = wire_bytes[i];
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ b[k];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return ~c;
  endfunction

  task automatic build_expected(input int stall);
    int         n_sent;
    logic [8:0] e;
    logic [7:0] b;
    logic [31:0] f;
    exp_d.delete();
    wire_bytes.delete();
    n_sent = (stall >= 0) ? stall : src.size();
    for (int i = 0; i < n_sent; i++) begin
      e = src[i];
      wire_bytes.push_back(e[7:0]);
    end
    if (stall < 0) while (wire_bytes.size() < 60) wire_bytes.push_back(8'h00);
    repeat (28) exp_d.push_back(2'b01);
    repeat (3) exp_d.push_back(2'b01);
    exp_d.push_back(2'b11);
    for (int i = 0; i < wire_bytes.size(); i++) begin
      b = wire_bytes[i];
      for (int k = 0; k < 4; k++) exp_d.push_back(b[2*k +: 2]);
    end
`ifdef PCILEECH_ETH_TX_FCS_EN
    if (stall < 0) begin
      f = fcs_of(wire_bytes.size());
      for (int k = 0; k < 16; k++) exp_d.push_back(f[2*k +: 2]);
    end
`else
    f = 32'h0;
`endif
  endtask

  task automatic compare_stream(input string name);
    int j, bad, first_bad;
    j = 0; bad = 0; first_bad = -1;
    for (int i = 0; i < log_en.size(); i++) begin
      if (log_en[i]) begin
        if (j >= exp_d.size() || log_d[i] !== exp_d[j]) begin
          if (first_bad < 0) first_bad = j;
          bad++;
        end
        j++;
      end
    end
    check({name, " dibit_count"}, j, exp_d.size());
    check({name, " dibit_errors"}, bad, 0);
    if (bad != 0) $display("  %s: first wrong dibit at position %0d", name, first_bad);
  endtask

  task automatic run_vec(input vec_t v);
    int hi, rises, first_hi, acc, rdy, ur, last_hi, last_acc, u, e;
    logic [1:0] pair;
    src.delete();
    load_frame(v.kind, v.len);
    stall_at = v.stall;
    start_run();
    run_to_idle(v.name);
    build_expected(v.stall);
    hi = 0; rises = 0; first_hi = -1; acc = 0; rdy = 0; ur = 0;
    last_hi = -1; last_acc = -1; u = -1;
    for (int i = 0; i < log_en.size(); i++) begin
      if (log_en[i]) begin
        hi++;
        last_hi = i;
        if (first_hi < 0) first_hi = i;
        if (i == 0 || !log_en[i-1]) rises++;
      end
      if (log_acc[i]) begin acc++; last_acc = i; end
      if (log_rdy[i]) rdy++;
      if (log_ur[i]) begin ur++; if (u < 0) u = i; end
    end
    e = (last_hi > last_acc) ? last_hi : last_acc;
    check({v.name, " tx_en_cycles"}, hi, v.exp_hi);
    check({v.name, " tx_en_rises"}, rises, v.exp_rises);
    check({v.name, " start_latency"}, first_hi, 1);
    check({v.name, " bytes_accepted"}, acc, v.exp_acc);
    check({v.name, " ready_cycles"}, rdy, v.exp_acc + v.exp_ur);
    check({v.name, " underrun_pulses"}, ur, v.exp_ur);
    check({v.name, " ifg_cycles"}, log_en.size() - 1 - e, v.exp_gap);
    if (v.exp_ur != 0) begin
      pair = (u >= 1) ? {log_en[u-1], log_en[u]} : 2'b00;
      check({v.name, " tx_en_drop_at_underrun"}, pair, 2'b10);
    end
    compare_stream(v.name);
  endtask

  vec_t vecs[6];

  initial begin
    #4000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int f1, r2, hi, rises;

    vecs[0] = '{"inc60",       0, 60,  -1, 272 + FCS_CYC, 1, 60,  0, IFG_CYC};
    vecs[1] = '{"crc9_pad",    1, 9,   -1, 272 + FCS_CYC, 1, 9,   0, IFG_CYC};
    vecs[2] = '{"one_a5",      2, 1,   -1, 272 + FCS_CYC, 1, 1,   0, IFG_CYC};
    vecs[3] = '{"crc64_nopad", 1, 64,  -1, 288 + FCS_CYC, 1, 64,  0, IFG_CYC};
    vecs[4] = '{"inc61",       0, 61,  -1, 276 + FCS_CYC, 1, 61,  0, IFG_CYC};
    vecs[5] = '{"underrun20",  0, 100, 20, 112,           1, 100, 1, IFG_CYC};

    // Reset holds outputs quiet even with a frame offered.
    rst = 1'b1;
    s_tvalid = 1'b1;
    s_tdata = 8'h55;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset tx_en", eth_tx_en, 0);
    check("reset tx_data", eth_tx_data, 0);
    check("reset tready", s_tready, 0);
    check("reset busy", busy, 0);
    check("reset underrun", underrun, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    s_tvalid = 1'b0;

    wire_bytes.delete();
    for (int i = 0; i < 9; i++) wire_bytes.push_back(8'h31 + 8'(i));
    check("crc_model 123456789", fcs_of(9), 32'hCBF43926);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Reset on the 10th preamble cycle.
    src.delete();
    load_frame(0, 60);
    stall_at = -1;
    start_run();
    cnt = 0;
    for (int c = 0; c < 40 && cnt < 9; c++) begin
      step();
      if (log_en[log_en.size()-1]) cnt++;
    end
    check("rst preamble_reached", cnt, 9);
    rst = 1'b1;
    step();
    check("rst cycle10 tx_en", log_en[log_en.size()-1], 1);
    rst = 1'b0;
    src.delete();
    drive_inputs();
    step();
    check("rst after tx_en", log_en[log_en.size()-1], 0);
    check("rst after busy", log_busy[log_busy.size()-1], 0);
    check("rst after underrun", log_ur[log_ur.size()-1], 0);
    check("rst after tready", log_rdy[log_rdy.size()-1], 0);
    run_vec('{"post_rst", 0, 60, -1, 272 + FCS_CYC, 1, 60, 0, IFG_CYC});

    // Back-to-back frames with s_tvalid held high through the gap.
    src.delete();
    load_frame(0, 60);
    load_frame(2, 1);
    stall_at = -1;
    start_run();
    run_to_idle("b2b");
    f1 = -1; r2 = -1; hi = 0; rises = 0;
    for (int i = 1; i < log_en.size(); i++) begin
      if (f1 < 0 && log_en[i-1] && !log_en[i]) f1 = i;
      if (f1 >= 0 && r2 < 0 && !log_en[i-1] && log_en[i]) r2 = i;
    end
    for (int i = 0; i < log_en.size(); i++) begin
      if (log_en[i]) hi++;
      if (log_en[i] && (i == 0 || !log_en[i-1])) rises++;
    end
    check("b2b gap_cycles", (f1 >= 0 && r2 >= 0) ? (r2 - f1) : -1, IFG_CYC);
    check("b2b rises", rises, 2);
    check("b2b tx_en_cycles", hi, 2 * (272 + FCS_CYC));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
